// File: rtl/reset_stream_writer.sv
`default_nettype none
// ============================================================================
// Module      : reset_stream_writer
// Description : Turns a reset request into a burst of PULSE_LEN "1" writes into
//               a reset-crossing FIFO, then holds off for GAP idle cycles.
//               Optional stats counters: define RESET_STREAM_WRITER_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_stream_writer #(
    parameter int PULSE_LEN = 4,
    parameter int GAP       = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic        fifo_din,
    output logic        busy,
    output logic        pending
`ifdef RESET_STREAM_WRITER_STATS_EN
    ,
    output logic [15:0] req_count,
    output logic [15:0] coalesce_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PUSH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] c_PULSE_LEN = 8'(PULSE_LEN);
    localparam logic [7:0] c_GAP       = 8'(GAP);

    state_t     state_q;
    logic [7:0] beat_q;
    logic [7:0] beat_d;
    logic [7:0] gap_q;
    logic       pending_q;

    // Write is gated by reset and full so nothing escapes while either is active.
    assign fifo_wr_en = reset && (state_q == S_PUSH) && !fifo_full;
    assign fifo_din   = fifo_wr_en;
    assign busy       = (state_q != S_IDLE);
    assign pending    = pending_q;
    assign beat_d     = beat_q + 8'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            beat_q    <= 8'd0;
            gap_q     <= 8'd0;
            pending_q <= 1'b0;
        end else begin
            if (req && (state_q != S_IDLE)) begin
                pending_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (req || pending_q) begin
                        state_q   <= S_PUSH;
                        pending_q <= 1'b0;
                        beat_q    <= 8'd0;
                    end
                end
                S_PUSH: begin
                    if (fifo_wr_en) begin
                        beat_q <= beat_d;
                        if (beat_d == c_PULSE_LEN) begin
                            if (c_GAP == 8'd0) begin
                                state_q <= S_IDLE;
                            end else begin
                                state_q <= S_GAP;
                                gap_q   <= c_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    gap_q <= gap_q - 8'd1;
                    if (gap_q <= 8'd1) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef RESET_STREAM_WRITER_STATS_EN
    logic [15:0] req_count_q;
    logic [15:0] coalesce_count_q;

    assign req_count      = req_count_q;
    assign coalesce_count = coalesce_count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            req_count_q      <= 16'd0;
            coalesce_count_q <= 16'd0;
        end else begin
            if ((state_q == S_IDLE) && (req || pending_q) && (req_count_q != 16'hFFFF)) begin
                req_count_q <= req_count_q + 16'd1;
            end
            // A request is only "coalesced" once a follow-up burst is already queued.
            if (req && (state_q != S_IDLE) && pending_q && (coalesce_count_q != 16'hFFFF)) begin
                coalesce_count_q <= coalesce_count_q + 16'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/reset_stream_writer.md
Name: reset_stream_writer

Overview:
Source-domain writer for the single-bit reset-crossing stream FIFO. It converts a reset request in its own clock domain into a burst of PULSE_LEN "1" entries written into the FIFO write port. The destination-side reader emits one reset cycle per entry it drains, so each burst becomes a destination reset pulse of PULSE_LEN cycles. It also enforces an idle gap between bursts and coalesces requests that arrive while a burst is in progress.

Parameters:
PULSE_LEN, 4, FIFO entries written per burst; legal range 1..255.
GAP, 8, idle cycles after the last write of a burst before the next burst may start; legal range 0..255.

Ports:
clk  input  1  write-side clock; only clock.
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk.
req  input  1  reset request; sampled every rising edge; a level held high counts as one request per sample.
fifo_full  input  1  FIFO write-port full flag.
fifo_wr_en  output  1  FIFO write enable.
fifo_din  output  1  FIFO write data; equals fifo_wr_en.
busy  output  1  high in PUSH or GAP state.
pending  output  1  a coalesced request is waiting for the next burst.

Behaviour:
- reset low at a rising edge: state=IDLE, beat counter=0, gap counter=0, pending=0, stats counters=0.
- fifo_wr_en = reset && (state==PUSH) && !fifo_full. It is combinational, so no write occurs in any cycle where reset is low or the FIFO is full.
- fifo_din = fifo_wr_en.
- busy = (state != IDLE), decoded from the state register.
- IDLE:
  - If req or pending: go to PUSH, clear pending, clear beat counter.
  - Otherwise stay in IDLE.
- PUSH:
  - Each cycle with fifo_wr_en high, the beat counter increments.
  - On the write that makes beat == PULSE_LEN: go to GAP, loading the gap counter with GAP. If GAP==0, go to IDLE instead.
  - While fifo_full is high: hold state and counter. No write, no loss, no duplicate.
- GAP:
  - Decrement the gap counter each cycle.
  - Go to IDLE on the cycle the counter reaches 1.
  - Exactly GAP cycles are spent in GAP.
- req while state != IDLE sets pending=1. It saturates, so any number of requests during one burst plus gap produces exactly one follow-up burst.
- req in the last GAP cycle sets pending; that request is served in the following IDLE cycle.
- Latency, FIFO never full:
  - req high in cycle 0 gives fifo_wr_en high in cycles 1..PULSE_LEN.
  - busy is high in cycles 1..PULSE_LEN+GAP.
  - The earliest next write is in cycle PULSE_LEN+GAP+2 (one IDLE cycle between bursts).
- Back-pressure: total writes per burst is exactly PULSE_LEN regardless of fifo_full pattern. Writes need not be contiguous.
- Reset mid-burst:
  - The burst is abandoned and the remaining writes are dropped.
  - Pending is cleared.
  - Already-written entries stay in the FIFO; the destination sees a shortened pulse. This is accepted.
- Counter widths: 8 bits for beat and gap counters.

Optional Feature:
Macro RESET_STREAM_WRITER_STATS_EN.
- When defined, add two outputs:
  - req_count (16 bits): increments for each IDLE-to-PUSH transition.
  - coalesce_count (16 bits): increments for each req sample while state != IDLE and pending is already 1.
- Both counters saturate at 16'hFFFF and clear on reset.
- When undefined, neither port nor logic exists, and all other behaviour is identical.

Test Plan:
- PULSE_LEN=4, GAP=8, fifo_full=0; single-cycle req at cycle 0 -> fifo_wr_en=fifo_din=1 in cycles 1-4 only; busy high cycles 1-12; pending stays 0.
- Same config; fifo_full forced high cycles 2-4 -> writes in cycles 1, 5, 6, 7; exactly 4 writes; no write while full.
- req pulses at cycles 0, 3, 6 -> first burst at cycles 1-4; pending=1 from cycle 4; second burst at cycles 14-17; no third burst.
- GAP=0, req held high cycles 0-20 -> bursts of 4 writes separated by exactly one IDLE cycle (writes at cycles 1-4, 6-9, ...).
- reset driven low at cycle 2 of a burst (after 1 write) -> no write in cycle 2; IDLE, pending=0, busy=0 after the edge; next req produces a full 4-write burst.
- With RESET_STREAM_WRITER_STATS_EN, the third scenario -> req_count=2, coalesce_count=1; after reset both read 0.
